local_bus_rr_arbiter: RTL and testbench

- Round-robin arbiter and transaction sequencer for the shared 16-bit local bus. Masters include the USB_RAM_Reg bridge and future DMA/CPU masters; slaves include test RAM and register files.
- Grants the bus to one master at a time and opens the address phase (target_ready). It waits for the registered slave decode (address_valid), then issues a single data_strobe.
- Reports a timeout error when no slave claims the address. Sits between the masters' barq/bagd pairs and the bus address decoder and mux.

---
 rtl/local_bus_rr_arbiter_pkg.sv | 22 ++
 rtl/local_bus_rr_arbiter_rr_priority_picker.sv | 40 ++++
 rtl/local_bus_rr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_local_bus_rr_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/local_bus_rr_arbiter_pkg.sv
// Shared types and defaults for the local-bus round-robin arbiter.
package local_bus_rr_arbiter_pkg;

    localparam int unsigned NUM_MASTERS = 4;
    localparam int unsigned ARB_TIMEOUT = 10;
    localparam int unsigned ERR_COUNT_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        ABORT   = 3'd4,
        RELEASE = 3'd5
    } arb_state_t;

    // Saturating increment for the timeout counter
    function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] v);
        return (v == {ERR_COUNT_W{1'b1}}) ? v : v + ERR_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/local_bus_rr_arbiter_rr_priority_picker.sv
// Combinational round-robin pick: first requester strictly after last_grant.
module rr_priority_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    int unsigned          start;
    int unsigned          offset;
    int unsigned          sum;

    // Rotate so the master after last_grant lands on bit 0, then take the lowest set bit
    always_comb begin
        start = 32'(last_grant) + 32'd1;
        if (start >= NUM_REQ) begin
            start = 32'd0;
        end
        req_dbl = {req, req};
        req_rot = NUM_REQ'(req_dbl >> start);
        offset  = 32'd0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = 32'(i);
            end
        end
        sum = start + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        found = |req;
        idx   = IDX_W'(sum);
    end

endmodule

// File: rtl/local_bus_rr_arbiter.sv
// Round-robin arbiter and single-strobe transaction sequencer for the 16-bit local bus.
module local_bus_rr_arbiter #(
    parameter int unsigned NUM_MASTERS     = local_bus_rr_arbiter_pkg::NUM_MASTERS,
    parameter int unsigned CLK_MAX_TIMEOUT = local_bus_rr_arbiter_pkg::ARB_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         barq_i,
    output logic [NUM_MASTERS-1:0]         bagd_o,
    output logic                           target_ready_o,
    input  logic                           address_valid_i,
    output logic                           data_strobe_o,
    output logic                           error_o,
    output logic [$clog2(NUM_MASTERS)-1:0] err_master_o,
    output logic [7:0]                     err_count_o,
    output logic                           busy_o
);

    import local_bus_rr_arbiter_pkg::*;

    localparam int unsigned IDX_W   = $clog2(NUM_MASTERS);
    localparam int unsigned TIMER_W = $clog2(CLK_MAX_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLK_MAX_TIMEOUT - 1);
    localparam logic [IDX_W-1:0]   LAST_INIT  = IDX_W'(NUM_MASTERS - 1);

    arb_state_t             state;
    arb_state_t             state_nxt;
    logic [IDX_W-1:0]       gnt_idx;
    logic [IDX_W-1:0]       gnt_idx_nxt;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       last_grant_nxt;
    logic [TIMER_W-1:0]     timer;
    logic [TIMER_W-1:0]     timer_nxt;
    logic [NUM_MASTERS-1:0] bagd_nxt;
    logic                   target_ready_nxt;
    logic                   data_strobe_nxt;
    logic                   error_nxt;
    logic [IDX_W-1:0]       err_master_nxt;
    logic [7:0]             err_count_nxt;
    logic                   busy_nxt;
    logic                   gnt_req;
    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;

    rr_priority_picker #(
        .NUM_REQ (NUM_MASTERS),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (barq_i),
        .last_grant (last_grant),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output decode; every output is flopped below
    always_comb begin
        state_nxt        = state;
        gnt_idx_nxt      = gnt_idx;
        last_grant_nxt   = last_grant;
        timer_nxt        = timer;
        bagd_nxt         = bagd_o;
        target_ready_nxt = target_ready_o;
        data_strobe_nxt  = 1'b0;
        error_nxt        = 1'b0;
        err_master_nxt   = err_master_o;
        err_count_nxt    = err_count_o;
        gnt_req          = barq_i[gnt_idx];

        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt        = ADDR;
                    gnt_idx_nxt      = pick_idx;
                    bagd_nxt         = NUM_MASTERS'(1) << pick_idx;
                    target_ready_nxt = 1'b1;
                    timer_nxt        = '0;
                end
            end
            ADDR: begin
                if (!gnt_req) begin
                    state_nxt        = ABORT;
                    bagd_nxt         = '0;
                    target_ready_nxt = 1'b0;
                    last_grant_nxt   = gnt_idx;
                end else if (address_valid_i) begin
                    state_nxt       = STROBE;
                    data_strobe_nxt = 1'b1;
                end else if (timer == TIMER_LAST) begin
                    state_nxt        = RELEASE;
                    bagd_nxt         = '0;
                    target_ready_nxt = 1'b0;
                    error_nxt        = 1'b1;
                    err_master_nxt   = gnt_idx;
                    err_count_nxt    = sat_inc(err_count_o);
                    last_grant_nxt   = gnt_idx;
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end
            STROBE: begin
                state_nxt        = HOLD;
                target_ready_nxt = 1'b0;
            end
            HOLD: begin
                if (!gnt_req) begin
                    state_nxt      = RELEASE;
                    bagd_nxt       = '0;
                    last_grant_nxt = gnt_idx;
                end
            end
            ABORT, RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt        = IDLE;
                bagd_nxt         = '0;
                target_ready_nxt = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // Registered outputs and datapath; reset drops grant and strobe immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_idx        <= '0;
            last_grant     <= LAST_INIT;
            timer          <= '0;
            bagd_o         <= '0;
            target_ready_o <= 1'b0;
            data_strobe_o  <= 1'b0;
            error_o        <= 1'b0;
            err_master_o   <= '0;
            err_count_o    <= '0;
            busy_o         <= 1'b0;
        end else begin
            gnt_idx        <= gnt_idx_nxt;
            last_grant     <= last_grant_nxt;
            timer          <= timer_nxt;
            bagd_o         <= bagd_nxt;
            target_ready_o <= target_ready_nxt;
            data_strobe_o  <= data_strobe_nxt;
            error_o        <= error_nxt;
            err_master_o   <= err_master_nxt;
            err_count_o    <= err_count_nxt;
            busy_o         <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_local_bus_rr_arbiter.sv
// Scoreboard bench for local_bus_rr_arbiter: driver predicts bus events, monitor checks them.
module tb_local_bus_rr_arbiter;

    localparam int NM = 4;
    localparam int TO = 10;

    localparam int EV_GRANT  = 0;
    localparam int EV_STROBE = 1;
    localparam int EV_TRDROP = 2;
    localparam int EV_ERROR  = 3;
    localparam int EV_DROP   = 4;

    typedef struct {
        int kind;
        int master;
        int cyc;
        int cnt;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NM-1:0] barq;
    logic [NM-1:0] bagd;
    logic          target_ready;
    logic          address_valid;
    logic          data_strobe;
    logic          error;
    logic [1:0]    err_master;
    logic [7:0]    err_count;
    logic          busy;

    int      cyc   = 0;
    int      tests = 0;
    int      fails = 0;
    ev_t     exp_q[$];
    bit      mon_en = 1'b0;
    int      last_m;
    int      cnt_m;
    logic [NM-1:0] prev_bagd = '0;
    logic          prev_tr   = 1'b0;

    local_bus_rr_arbiter #(
        .NUM_MASTERS     (NM),
        .CLK_MAX_TIMEOUT (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .barq_i          (barq),
        .bagd_o          (bagd),
        .target_ready_o  (target_ready),
        .address_valid_i (address_valid),
        .data_strobe_o   (data_strobe),
        .error_o         (error),
        .err_master_o    (err_master),
        .err_count_o     (err_count),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference rule: first requester strictly after the last grant, wrapping
    function automatic int model_pick(input logic [NM-1:0] r, input int last);
        for (int k = 1; k <= NM; k++) begin
            int c;
            c = (last + k) % NM;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic int oh_index(input logic [NM-1:0] v);
        for (int k = 0; k < NM; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic push(input int kind, input int m, input int c, input int n);
        ev_t e;
        e.kind = kind;
        e.master = m;
        e.cyc = c;
        e.cnt = n;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int m, input int c, input int n);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event got kind=%0d master=%0d cyc=%0d cnt=%0d, nothing expected",
                     kind, m, c, n);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.master != m || e.cyc != c || e.cnt != n) begin
                fails++;
                $display("FAIL bus_event got kind=%0d master=%0d cyc=%0d cnt=%0d, expected kind=%0d master=%0d cyc=%0d cnt=%0d",
                         kind, m, c, n, e.kind, e.master, e.cyc, e.cnt);
            end
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d (cyc=%0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_bagd"}, int'(bagd), 0);
        check_val({tag, "_target_ready"}, int'(target_ready), 0);
        check_val({tag, "_data_strobe"}, int'(data_strobe), 0);
        check_val({tag, "_error"}, int'(error), 0);
        check_val({tag, "_err_master"}, int'(err_master), 0);
        check_val({tag, "_err_count"}, int'(err_count), 0);
        check_val({tag, "_busy"}, int'(busy), 0);
    endtask

    // Monitor: turn DUT output activity into events and compare against the queue
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check_val("bagd_onehot", ($countones(bagd) <= 1) ? 1 : 0, 1);
            if (prev_bagd == '0 && bagd != '0) begin
                check_ev(EV_GRANT, oh_index(bagd), cyc, 0);
                check_val("grant_target_ready", int'(target_ready), 1);
            end
            if (data_strobe) begin
                check_ev(EV_STROBE, oh_index(bagd), cyc, 0);
            end
            if (prev_tr && !target_ready && bagd != '0) begin
                check_ev(EV_TRDROP, oh_index(bagd), cyc, 0);
            end
            if (error) begin
                check_ev(EV_ERROR, int'(err_master), cyc, int'(err_count));
            end
            if (prev_bagd != '0 && bagd == '0) begin
                check_ev(EV_DROP, oh_index(prev_bagd), cyc, 0);
            end
        end
        prev_bagd <= bagd;
        prev_tr   <= target_ready;
    end

    // One grant from an idle arbiter. scen: 0 normal, 1 abort, 2 timeout.
    task automatic txn(input int scen, input int d, input int h, input logic [NM-1:0] new_bits,
                       input bit clr, input bit rereq, input bit noise, input bit drop_after_to);
        int            w;
        int            g;
        int            s;
        logic [NM-1:0] r;
        logic [NM-1:0] oh;
        check_val("busy_idle", int'(busy), 0);
        r = clr ? '0 : barq;
        r = r | new_bits;
        if (r == '0) r = NM'(1) << $urandom_range(NM - 1, 0);
        barq = r;
        w = model_pick(r, last_m);
        oh = NM'(1) << w;
        g = cyc + 1;
        push(EV_GRANT, w, g, 0);
        step();
        check_val("busy_granted", int'(busy), 1);
        if (noise) barq = (barq & oh) | (NM'($urandom) & ~oh);
        if (scen == 0) begin
            repeat (d) step();
            address_valid = 1'b1;
            s = cyc + 1;
            push(EV_STROBE, w, s, 0);
            push(EV_TRDROP, w, s + 1, 0);
            step();
            address_valid = 1'b0;
            repeat (h) begin
                address_valid = 1'($urandom_range(1, 0));
                step();
            end
            address_valid = 1'b0;
            barq[w] = 1'b0;
            push(EV_DROP, w, cyc + 1, 0);
            step();
        end else if (scen == 1) begin
            repeat (d) step();
            barq[w] = 1'b0;
            push(EV_DROP, w, cyc + 1, 0);
            step();
        end else begin
            cnt_m = (cnt_m < 255) ? cnt_m + 1 : 255;
            push(EV_ERROR, w, g + TO, cnt_m);
            push(EV_DROP, w, g + TO, 0);
            repeat (TO) step();
            if (drop_after_to) barq[w] = 1'b0;
        end
        last_m = w;
        if (rereq) barq[w] = 1'b1;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sc;
        rst = 1'b1;
        barq = '0;
        address_valid = 1'b0;
        last_m = NM - 1;
        cnt_m = 0;
        #1;
        check_all_zero("reset");
        repeat (3) step();
        rst = 1'b0;
        mon_en = 1'b1;

        // Single master 0, slave answers two cycles into the address phase
        txn(0, 2, 2, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);

        // Everyone requesting; each master re-requests right after its release
        for (int i = 0; i < 8; i++) begin
            txn(0, int'($urandom_range(3, 0)), 1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Master 2 alone, slave never claims the address
        txn(2, 0, 0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("err_master_after_timeout", int'(err_master), 2);
        check_val("err_count_after_timeout", int'(err_count), 1);

        // Master 1 gives up mid address phase, then master 3 gets the bus
        txn(1, 3, 0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
        txn(0, 1, 1, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("err_count_after_abort", int'(err_count), 1);

        // Randomized mix of normal, abort and timeout transactions
        for (int i = 0; i < 150; i++) begin
            sc = int'($urandom_range(9, 0));
            txn((sc < 6) ? 0 : ((sc < 8) ? 1 : 2),
                int'($urandom_range(6, 0)), int'($urandom_range(3, 1)),
                NM'($urandom), 1'($urandom_range(3, 0) == 0), 1'($urandom_range(1, 0)),
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        // Asynchronous reset while the strobe is on the bus
        barq = 4'b0100;
        push(EV_GRANT, 2, cyc + 1, 0);
        step();
        address_valid = 1'b1;
        push(EV_STROBE, 2, cyc + 1, 0);
        step();
        address_valid = 1'b0;
        check_val("strobe_before_reset", int'(data_strobe), 1);
        mon_en = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        barq = 4'b1111;
        step();
        step();
        rst = 1'b0;
        last_m = NM - 1;
        cnt_m = 0;
        mon_en = 1'b1;
        txn(0, 1, 1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Long run of timeouts to saturate the error counter
        for (int i = 0; i < 260; i++) begin
            txn(2, 0, 0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check_val("err_count_saturated", int'(err_count), 255);

        barq = '0;
        repeat (5) step();
        check_val("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
